// File: rtl/dot_product_acc_if.sv
// Handshake bundle for dot_product_acc: input beat channel, result channel and busy.
// The DUT takes the slave view; the producer/consumer takes the master view.
interface dot_product_acc_if #(
    parameter int IN_SIZE_0  = 4,
    parameter int IN_SIZE_1  = 8,
    parameter int SIZE_ARRAY = 8,
    parameter int ACC_GUARD  = 8,
    parameter int LEN_WIDTH  = 8
) ();
    localparam int OUT_SIZE = IN_SIZE_0 + IN_SIZE_1 + ACC_GUARD;

    logic                                  signed_i;
    logic [LEN_WIDTH-1:0]                  len_i;
    logic                                  in_valid_i;
    logic                                  in_ready_o;
    logic [SIZE_ARRAY-1:0][IN_SIZE_0-1:0]  in_0_i;
    logic [SIZE_ARRAY-1:0][IN_SIZE_1-1:0]  in_1_i;
    logic                                  out_valid_o;
    logic                                  out_ready_i;
    logic [OUT_SIZE-1:0]                   out_o;
    logic                                  out_ovf_o;
    logic                                  busy_o;

    modport slave (
        input  signed_i, len_i, in_valid_i, in_0_i, in_1_i, out_ready_i,
        output in_ready_o, out_valid_o, out_o, out_ovf_o, busy_o
    );

    modport master (
        output signed_i, len_i, in_valid_i, in_0_i, in_1_i, out_ready_i,
        input  in_ready_o, out_valid_o, out_o, out_ovf_o, busy_o
    );
endinterface

// File: rtl/dot_product_acc.sv
// Multi-beat dot-product accumulator: multiply stage, registered adder tree, accumulator,
// and a small job FSM that returns one resolved sum per job of len_i beats.
module dot_product_acc #(
    parameter int IN_SIZE_0  = 4,
    parameter int IN_SIZE_1  = 8,
    parameter int SIZE_ARRAY = 8,
    parameter int ACC_GUARD  = 8,
    parameter int LEN_WIDTH  = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    dot_product_acc_if.slave bus
);
    localparam int PROD_W   = IN_SIZE_0 + IN_SIZE_1;
    localparam int OUT_SIZE = PROD_W + ACC_GUARD;
    localparam logic [LEN_WIDTH-1:0] LEN_ONE = LEN_WIDTH'(1);

    typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, OUT} state_e;

    state_e                           state_q, state_d;
    logic                             mode_q, mode_d;
    logic [LEN_WIDTH-1:0]             len_q, len_d, cnt_q, cnt_d;
    logic                             in_ready_q, in_ready_d;
    logic                             out_valid_q, out_valid_d;
    logic                             busy_q, busy_d;
    logic [SIZE_ARRAY-1:0][PROD_W-1:0] prod_q, prod_d;
    logic                             s1_valid_q, s1_valid_d, s1_last_q, s1_last_d;
    logic                             s2_valid_q, s2_valid_d, s2_last_q, s2_last_d;
    logic                             s3_last_q, s3_last_d;
    logic [OUT_SIZE-1:0]              tree_q, tree_d, acc_q, acc_d, out_q, out_d;
    logic                             ovf_q, ovf_d, out_ovf_q, out_ovf_d;

    logic                             accept;
    logic                             mode_cur;
    logic [LEN_WIDTH-1:0]             len_eff, cnt_inc;
    logic [OUT_SIZE:0]                sum_w;
    logic                             s_ovf;

    // Low PROD_W bits of the product are the same whether the operands are treated
    // as signed or unsigned once they are extended to PROD_W, so one multiplier serves both modes.
    function automatic logic [PROD_W-1:0] mul_ext(input logic [IN_SIZE_0-1:0] a,
                                                  input logic [IN_SIZE_1-1:0] b,
                                                  input logic             s);
        logic [PROD_W-1:0] ea, eb;
        ea = {{(PROD_W-IN_SIZE_0){s & a[IN_SIZE_0-1]}}, a};
        eb = {{(PROD_W-IN_SIZE_1){s & b[IN_SIZE_1-1]}}, b};
        return ea * eb;
    endfunction

    function automatic logic [OUT_SIZE-1:0] widen(input logic [PROD_W-1:0] p, input logic s);
        return {{ACC_GUARD{s & p[PROD_W-1]}}, p};
    endfunction

    assign accept   = bus.in_valid_i && in_ready_q;
    assign mode_cur = (state_q == IDLE) ? bus.signed_i : mode_q;
    assign len_eff  = (bus.len_i == '0) ? LEN_ONE : bus.len_i;
    assign cnt_inc  = cnt_q + LEN_ONE;
    assign sum_w    = {1'b0, acc_q} + {1'b0, tree_q};
    assign s_ovf    = (acc_q[OUT_SIZE-1] == tree_q[OUT_SIZE-1]) &&
                      (sum_w[OUT_SIZE-1] != acc_q[OUT_SIZE-1]);

    // NOTE: every always_comb output gets a default first, so no path leaves it unassigned
    // and no latch is inferred.
    always_comb begin
        prod_d     = prod_q;
        s1_valid_d = accept;
        s2_valid_d = s1_valid_q;
        s2_last_d  = s1_valid_q & s1_last_q;
        s3_last_d  = s2_valid_q & s2_last_q;
        tree_d     = tree_q;
        acc_d      = acc_q;
        ovf_d      = ovf_q;

        if (accept) begin
            for (int i = 0; i < SIZE_ARRAY; i++) begin
                prod_d[i] = mul_ext(bus.in_0_i[i], bus.in_1_i[i], mode_cur);
            end
        end

        if (s1_valid_q) begin
            tree_d = '0;
            for (int i = 0; i < SIZE_ARRAY; i++) begin
                tree_d = tree_d + widen(prod_q[i], mode_q);
            end
        end

        if (state_q == IDLE && accept) begin
            acc_d = '0;
            ovf_d = 1'b0;
        end else if (s2_valid_q) begin
            acc_d = sum_w[OUT_SIZE-1:0];
            ovf_d = ovf_q | (mode_q ? s_ovf : sum_w[OUT_SIZE]);
        end
    end

    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        len_d     = len_q;
        cnt_d     = cnt_q;
        s1_last_d = 1'b0;
        out_d     = out_q;
        out_ovf_d = out_ovf_q;

        case (state_q)
            IDLE: if (accept) begin
                mode_d    = bus.signed_i;
                len_d     = len_eff;
                cnt_d     = LEN_ONE;
                s1_last_d = (len_eff == LEN_ONE);
                state_d   = (len_eff == LEN_ONE) ? DRAIN : ACCUM;
            end
            ACCUM: if (accept) begin
                cnt_d = cnt_inc;
                if (cnt_inc == len_q) begin
                    s1_last_d = 1'b1;
                    state_d   = DRAIN;
                end
            end
            DRAIN: if (s3_last_q) begin
                out_d     = acc_q;
                out_ovf_d = ovf_q;
                state_d   = OUT;
            end
            OUT: if (bus.out_ready_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Handshake outputs are registered, so derive them from the next state.
        in_ready_d  = (state_d == IDLE) || (state_d == ACCUM);
        out_valid_d = (state_d == OUT);
        busy_d      = (state_d != IDLE);
    end

    // NOTE: datapath registers are reset along with the valids so out_o and every stage
    // start from a known value; the valid bits alone already decide what counts.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            mode_q      <= 1'b0;
            len_q       <= '0;
            cnt_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            prod_q      <= '0;
            s1_valid_q  <= 1'b0;
            s1_last_q   <= 1'b0;
            s2_valid_q  <= 1'b0;
            s2_last_q   <= 1'b0;
            s3_last_q   <= 1'b0;
            tree_q      <= '0;
            acc_q       <= '0;
            ovf_q       <= 1'b0;
            out_q       <= '0;
            out_ovf_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q     <= state_d;
            mode_q      <= mode_d;
            len_q       <= len_d;
            cnt_q       <= cnt_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            prod_q      <= prod_d;
            s1_valid_q  <= s1_valid_d;
            s1_last_q   <= s1_last_d;
            s2_valid_q  <= s2_valid_d;
            s2_last_q   <= s2_last_d;
            s3_last_q   <= s3_last_d;
            tree_q      <= tree_d;
            acc_q       <= acc_d;
            ovf_q       <= ovf_d;
            out_q       <= out_d;
            out_ovf_q   <= out_ovf_d;
        end
    end

    assign bus.in_ready_o  = in_ready_q;
    assign bus.out_valid_o = out_valid_q;
    assign bus.busy_o      = busy_q;
    assign bus.out_o       = out_q;
    assign bus.out_ovf_o   = out_ovf_q;
endmodule

// File: tb/tb_dot_product_acc.sv
// Scoreboard bench for dot_product_acc: each job's expected sum/overflow is modelled
// from the stimulus and queued, then popped when the DUT presents its result.
module tb_dot_product_acc;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    dot_product_acc_if bus ();

    dot_product_acc dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    typedef struct {
        logic [19:0] out;
        logic        ovf;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    function automatic longint beat_sum(input logic [7:0][3:0] a, input logic [7:0][7:0] b,
                                        input bit s);
        longint sum, x, y;
        sum = 0;
        for (int i = 0; i < 8; i++) begin
            x = s ? longint'($signed(a[i])) : longint'(a[i]);
            y = s ? longint'($signed(b[i])) : longint'(b[i]);
            sum += x * y;
        end
        return sum;
    endfunction

    // Returns #1 after the edge on which the beat was accepted.
    task automatic send_beat(input logic [7:0][3:0] a, input logic [7:0][7:0] b, input bit s,
                             input logic [7:0] len);
        int t;
        bus.in_0_i     = a;
        bus.in_1_i     = b;
        bus.signed_i   = s;
        bus.len_i      = len;
        bus.in_valid_i = 1'b1;
        t = 0;
        while (bus.in_ready_o !== 1'b1 && t < 100) begin
            @(posedge clk);
            #1;
            t++;
        end
        if (t >= 100) begin
            total++;
            bad++;
            $display("FAIL accept_timeout: in_ready_o=%b required 1", bus.in_ready_o);
        end
        @(posedge clk);
        #1;
        bus.in_valid_i = 1'b0;
    endtask

    task automatic send_job(input int len_field, input bit s, input int gap, input bit rnd,
                            input logic [3:0] a_c, input logic [7:0] b_c);
        int               n;
        exp_t             e;
        logic [19:0]      acc;
        bit               ovf;
        longint           bs, nxt;
        logic [7:0][3:0]  a;
        logic [7:0][7:0]  b;
        n   = (len_field == 0) ? 1 : len_field;
        acc = '0;
        ovf = 1'b0;
        for (int k = 0; k < n; k++) begin
            for (int i = 0; i < 8; i++) begin
                a[i] = rnd ? 4'($urandom) : a_c;
                b[i] = rnd ? 8'($urandom) : b_c;
            end
            bs  = beat_sum(a, b, s);
            nxt = s ? longint'($signed(acc)) + bs : longint'(acc) + bs;
            if (s ? (nxt > 524287 || nxt < -524288) : (nxt > 1048575)) ovf = 1'b1;
            acc = nxt[19:0];
            send_beat(a, b, s, 8'(len_field));
            if (gap > 0) begin
                repeat (gap) @(posedge clk);
                #1;
            end
        end
        e.out = acc;
        e.ovf = ovf;
        exp_q.push_back(e);
    endtask

    task automatic get_result(output logic [19:0] o, output logic ov, output bit got);
        int t;
        t = 0;
        while (bus.out_valid_o !== 1'b1 && t < 60) begin
            @(posedge clk);
            #1;
            t++;
        end
        got = (bus.out_valid_o === 1'b1);
        o   = bus.out_o;
        ov  = bus.out_ovf_o;
        bus.out_ready_i = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready_i = 1'b0;
    endtask

    task automatic test_reset();
        bus.in_valid_i  = 1'b1;
        bus.out_ready_i = 1'b0;
        bus.signed_i    = 1'b0;
        bus.len_i       = 8'd1;
        bus.in_0_i      = '1;
        bus.in_1_i      = '1;
        rst_n           = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (bus.in_ready_o !== 1'b1 || bus.out_valid_o !== 1'b0 || bus.busy_o !== 1'b0 ||
            bus.out_o !== 20'd0 || bus.out_ovf_o !== 1'b0) begin
            bad++;
            $display("FAIL reset_state: rdy=%b vld=%b busy=%b out=%0d ovf=%b required 1 0 0 0 0",
                     bus.in_ready_o, bus.out_valid_o, bus.busy_o, bus.out_o, bus.out_ovf_o);
        end
        bus.in_valid_i = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // len=1 signed corner: (-8)*(-128)*8, with cycle-exact latency and busy checks.
    task automatic test_signed_single();
        logic [19:0] o;
        logic        ov;
        bit          got;
        exp_t        e;
        send_job(1, 1'b1, 0, 1'b0, 4'h8, 8'h80);
        total++;
        if (bus.busy_o !== 1'b1 || bus.in_ready_o !== 1'b0) begin
            bad++;
            $display("FAIL t1_after_accept: busy=%b rdy=%b required 1 0", bus.busy_o, bus.in_ready_o);
        end
        for (int c = 1; c <= 2; c++) begin
            @(posedge clk);
            #1;
            total++;
            if (bus.out_valid_o !== 1'b0 || bus.busy_o !== 1'b1) begin
                bad++;
                $display("FAIL t1_early_edge%0d: vld=%b busy=%b required 0 1", c, bus.out_valid_o,
                         bus.busy_o);
            end
        end
        @(posedge clk);
        #1;
        total++;
        if (bus.out_valid_o !== 1'b1) begin
            bad++;
            $display("FAIL t1_latency: out_valid_o=%b at edge k+3 required 1", bus.out_valid_o);
        end
        get_result(o, ov, got);
        e = exp_q.pop_front();
        total++;
        if (!got || o !== e.out || ov !== e.ovf || o !== 20'd8192) begin
            bad++;
            $display("FAIL t1_result: out=%0d ovf=%b required out=%0d ovf=%b", o, ov, e.out, e.ovf);
        end
        total++;
        if (bus.busy_o !== 1'b0 || bus.in_ready_o !== 1'b1 || bus.out_valid_o !== 1'b0 ||
            bus.out_o !== o) begin
            bad++;
            $display("FAIL t1_after_handshake: busy=%b rdy=%b vld=%b out=%0d required 0 1 0 %0d",
                     bus.busy_o, bus.in_ready_o, bus.out_valid_o, bus.out_o, o);
        end
    endtask

    task automatic test_bubbles();
        logic [19:0] o;
        logic        ov;
        bit          got;
        exp_t        e;
        send_job(4, 1'b1, 2, 1'b0, 4'd7, 8'd127);
        get_result(o, ov, got);
        e = exp_q.pop_front();
        total++;
        if (!got || o !== e.out || ov !== e.ovf || o !== 20'd28448) begin
            bad++;
            $display("FAIL bubbles: out=%0d ovf=%b required out=%0d ovf=%b", o, ov, e.out, e.ovf);
        end
    endtask

    task automatic test_modes();
        logic [19:0] o;
        logic        ov;
        bit          got;
        exp_t        e;
        int          lens[4]  = '{1, 1, 0, 0};
        bit          sgn[4]   = '{1'b0, 1'b1, 1'b1, 1'b0};
        logic [19:0] want[4]  = '{20'd30600, 20'd8, 20'd8, 20'd30600};
        for (int k = 0; k < 4; k++) begin
            send_job(lens[k], sgn[k], 0, 1'b0, 4'hF, 8'hFF);
            get_result(o, ov, got);
            e = exp_q.pop_front();
            total++;
            if (!got || o !== e.out || ov !== e.ovf || o !== want[k]) begin
                bad++;
                $display("FAIL modes_len%0d_s%0d: out=%0d ovf=%b required out=%0d ovf=%b",
                         lens[k], sgn[k], o, ov, want[k], e.ovf);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [19:0]      o, o0;
        logic             ov;
        bit               got;
        int               t;
        exp_t             e, e2;
        logic [7:0][3:0]  a;
        logic [7:0][7:0]  b;
        send_job(3, 1'b0, 0, 1'b1, 4'd0, 8'd0);
        t = 0;
        while (bus.out_valid_o !== 1'b1 && t < 60) begin
            @(posedge clk);
            #1;
            t++;
        end
        o0 = bus.out_o;
        for (int i = 0; i < 8; i++) begin
            a[i] = 4'd9;
            b[i] = 8'd200;
        end
        bus.in_0_i     = a;
        bus.in_1_i     = b;
        bus.signed_i   = 1'b0;
        bus.len_i      = 8'd1;
        bus.in_valid_i = 1'b1;
        for (int c = 0; c < 5; c++) begin
            total++;
            if (bus.out_valid_o !== 1'b1 || bus.out_o !== o0 || bus.in_ready_o !== 1'b0 ||
                bus.busy_o !== 1'b1) begin
                bad++;
                $display("FAIL hold_cycle%0d: vld=%b out=%0d rdy=%b busy=%b required 1 %0d 0 1",
                         c, bus.out_valid_o, bus.out_o, bus.in_ready_o, bus.busy_o, o0);
            end
            @(posedge clk);
            #1;
        end
        bus.out_ready_i = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready_i = 1'b0;
        e = exp_q.pop_front();
        total++;
        if (o0 !== e.out || bus.out_ovf_o !== e.ovf) begin
            bad++;
            $display("FAIL held_result: out=%0d ovf=%b required out=%0d ovf=%b", o0, bus.out_ovf_o,
                     e.out, e.ovf);
        end
        total++;
        if (bus.busy_o !== 1'b0 || bus.in_ready_o !== 1'b1) begin
            bad++;
            $display("FAIL handshake_only: busy=%b rdy=%b required 0 1", bus.busy_o, bus.in_ready_o);
        end
        e2.out = 20'(beat_sum(a, b, 1'b0));
        e2.ovf = 1'b0;
        exp_q.push_back(e2);
        @(posedge clk);
        #1;
        bus.in_valid_i = 1'b0;
        get_result(o, ov, got);
        e = exp_q.pop_front();
        total++;
        if (!got || o !== e.out || ov !== e.ovf || o !== 20'd14400) begin
            bad++;
            $display("FAIL after_release: out=%0d ovf=%b required out=%0d ovf=%b", o, ov, e.out,
                     e.ovf);
        end
    endtask

    task automatic test_long_wrap();
        logic [19:0] o;
        logic        ov;
        bit          got;
        exp_t        e;
        send_job(255, 1'b1, 0, 1'b0, 4'd7, 8'd127);
        get_result(o, ov, got);
        e = exp_q.pop_front();
        total++;
        if (!got || o !== e.out || ov !== e.ovf || o !== 20'hBAC38 || ov !== 1'b1) begin
            bad++;
            $display("FAIL long_wrap: out=%h ovf=%b required out=%h ovf=%b", o, ov, e.out, e.ovf);
        end
        send_job(1, 1'b1, 0, 1'b0, 4'd7, 8'd127);
        get_result(o, ov, got);
        e = exp_q.pop_front();
        total++;
        if (!got || o !== e.out || ov !== 1'b0 || o !== 20'd7112) begin
            bad++;
            $display("FAIL ovf_cleared: out=%0d ovf=%b required out=%0d ovf=0", o, ov, e.out);
        end
    endtask

    task automatic test_mid_reset();
        logic [19:0]      o;
        logic             ov;
        bit               got;
        exp_t             e;
        logic [7:0][3:0]  a;
        logic [7:0][7:0]  b;
        for (int i = 0; i < 8; i++) begin
            a[i] = 4'd7;
            b[i] = 8'd127;
        end
        send_beat(a, b, 1'b1, 8'd4);
        send_beat(a, b, 1'b1, 8'd4);
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if (bus.out_o !== 20'd0 || bus.out_ovf_o !== 1'b0 || bus.out_valid_o !== 1'b0 ||
            bus.busy_o !== 1'b0 || bus.in_ready_o !== 1'b1) begin
            bad++;
            $display("FAIL mid_reset: out=%0d ovf=%b vld=%b busy=%b rdy=%b required 0 0 0 0 1",
                     bus.out_o, bus.out_ovf_o, bus.out_valid_o, bus.busy_o, bus.in_ready_o);
        end
        bus.in_valid_i = 1'b1;
        @(posedge clk);
        #1;
        total++;
        if (bus.busy_o !== 1'b0) begin
            bad++;
            $display("FAIL accept_in_reset: busy=%b required 0", bus.busy_o);
        end
        bus.in_valid_i = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        send_job(1, 1'b0, 0, 1'b0, 4'd3, 8'd5);
        get_result(o, ov, got);
        e = exp_q.pop_front();
        total++;
        if (!got || o !== e.out || ov !== e.ovf || o !== 20'd120) begin
            bad++;
            $display("FAIL post_reset_job: out=%0d ovf=%b required out=%0d ovf=%b", o, ov, e.out,
                     e.ovf);
        end
    endtask

    task automatic test_back_to_back();
        logic [19:0] o;
        logic        ov;
        bit          got;
        exp_t        e;
        int          len;
        bit          s;
        for (int k = 0; k < 8; k++) begin
            len = $urandom_range(1, 6);
            s   = 1'($urandom);
            send_job(len, s, (k < 4) ? 0 : int'($urandom_range(0, 1)), 1'b1, 4'd0, 8'd0);
            get_result(o, ov, got);
            e = exp_q.pop_front();
            total++;
            if (!got || o !== e.out || ov !== e.ovf) begin
                bad++;
                $display("FAIL b2b_job%0d len=%0d s=%0d: out=%0d ovf=%b required out=%0d ovf=%b",
                         k, len, s, o, ov, e.out, e.ovf);
            end
        end
    endtask

    initial begin
        test_reset();
        test_signed_single();
        test_bubbles();
        test_modes();
        test_backpressure();
        test_long_wrap();
        test_mid_reset();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
